cam_capture_window: RTL and testbench
=====================================

Name: cam_capture_window

Overview:
- Parametrised camera front-end for the ball-detection pipeline.
- Generates the sensor XCLK and synchronises the asynchronous href/vsync/pclk/data bus into the clk domain.
- Assembles multi-byte pixels and tracks column and row position.
- Emits only pixels inside a programmable crop window, with a linear buffer write address, for one frame per capture request or continuously.

Parameters:
- DATA_W, 8, sensor data bus width.
- BYTES_PER_PIX, 2, bus beats per pixel (1..4); the first beat is the most significant.
- XCLK_DIV, 4, clk cycles per xclk period; even, ≥2.
- H_W, 11, width of the column counter and window-x registers.
- V_W, 10, width of the row counter and window-y registers.
- ADDR_W, 12, width of the buffer write address.

Ports:
- clk  in  1  system clock.
- res  in  1  synchronous active-high reset.
- capture  in  1  one-cycle request to grab the next frame.
- continuous  in  1  when 1, re-arm automatically after each frame.
- cfg_x0  in  H_W  first accepted column.
- cfg_x1  in  H_W  last accepted column.
- cfg_y0  in  V_W  first accepted row.
- cfg_y1  in  V_W  last accepted row.
- ahref  in  1  async sensor line valid.
- avsync  in  1  async sensor frame sync (high between frames).
- apclk  in  1  async sensor pixel clock.
- adata  in  DATA_W  async sensor data.
- xclk  out  1  sensor master clock.
- pix_valid  out  1  one-cycle strobe for an in-window pixel.
- pix_data  out  DATA_W*BYTES_PER_PIX  assembled pixel.
- pix_addr  out  ADDR_W  buffer write address of pix_data.
- pix_x  out  H_W  column of the emitted pixel.
- pix_y  out  V_W  row of the emitted pixel.
- frame_start  out  1  one-cycle pulse when the active frame begins.
- frame_done  out  1  one-cycle pulse when the frame ends.
- busy  out  1  high from arm until frame_done.
- overrun  out  1  sticky; set when the address wraps; cleared on arm or reset.

Behaviour:
- Reset: every output and internal register is 0, and the FSM enters IDLE. A reset mid-frame abandons the frame with no frame_done.
- xclk:
  - Free-running; toggles every XCLK_DIV/2 clk cycles after reset.
  - Independent of FSM state.
- Synchronisers:
  - ahref, avsync and apclk each pass through a 2-flop synchroniser.
  - adata passes through an equal-depth 2-stage register, so it stays aligned with the synchronised apclk.
  - A third apclk flop provides edge detection; a pclk beat is a synchronised rising edge.
  - Input contract: apclk high and low each ≥2 clk cycles.
- Byte assembly:
  - A beat counter clears on the synchronised href rising edge.
  - Each beat inside href shifts in the aligned data byte.
  - On beat BYTES_PER_PIX the pixel is complete and the beat counter returns to 0.
  - A partial pixel at href falling is discarded.
- Position counters:
  - col clears at href rising and increments after each completed pixel; saturates at all-ones.
  - row clears at frame start and increments at href falling only if the line completed at least one pixel; saturates.
- Window and output:
  - A completed pixel is emitted iff cfg_x0 ≤ col ≤ cfg_x1 and cfg_y0 ≤ row ≤ cfg_y1, using the latched copies of the cfg values.
  - An empty window (x0>x1 or y0>y1) emits nothing, but the frame still completes.
  - pix_valid is registered and asserts the clk cycle after the final-beat edge is detected. pix_data, pix_x, pix_y and pix_addr are valid with it and hold otherwise.
  - pix_addr is 0 for the first emitted pixel of a frame and increments by 1 per emission, modulo 2^ADDR_W.
  - An increment from all-ones sets overrun.
- FSM:
  - IDLE: capture=1 → ARM. In ARM, latch cfg_*, clear overrun, and assert busy.
  - ARM: wait for synchronised avsync=1 → SYNC. This skips any partly-elapsed frame.
  - SYNC: on synchronised avsync falling → ACTIVE. Pulse frame_start; clear row, col and pix_addr.
  - ACTIVE: capture pixels. On synchronised avsync rising → DONE.
  - DONE: pulse frame_done for one cycle.
    - If continuous=1, go to SYNC; the FSM is already in vsync-high. Re-latch cfg and keep busy high.
    - If continuous=0, go to IDLE and drop busy.
- Pixels are accepted only in ACTIVE. href activity in other states is ignored.
- capture while busy is ignored. Dropping continuous mid-frame ends operation after the current frame.
- avsync rising mid-line ends the frame; the partial pixel is dropped.

Test Plan:
- Reset and xclk: hold res 3 cycles, XCLK_DIV=4 → all outputs 0; xclk period is 4 clk cycles starting low.
- Full frame:
  - Stimulus: window 0..3 × 0..1, BYTES_PER_PIX=2; sensor sends 2 lines of 4 pixels with bytes {8'hA5,8'h3C}.
  - Required: exactly 8 pix_valid pulses with pix_data 16'hA53C and pix_addr 0..7.
  - Required: pix_x/pix_y step through (0,0)…(3,1); one frame_start; one frame_done; busy falls.
- Cropping: 4 lines × 8 pixels, window x 2..5, y 1..2 → 8 pulses; first at (2,1) with addr 0, last at (5,2) with addr 7.
- Boundaries:
  - Odd byte before href falls → that pixel is not emitted and the next line starts on beat 0.
  - ADDR_W=3 with 10 in-window pixels → addr wraps 7→0 and overrun=1 stays high.
- Arm timing: capture asserted mid-ACTIVE of a sensor frame → no pixels until the following vsync-high/low; capture while busy is ignored.
- Continuous and reset:
  - continuous=1 over 2 frames → 2 frame_done pulses; busy high throughout; addr restarts at 0 each frame.
  - res mid-line → pix_valid=0, busy=0, no frame_done; a new capture works normally.

Source files
------------

// File: rtl/cam_capture_window.sv
`default_nettype none
// ============================================================================
//  Module   : cam_capture_window
//  Purpose  : Camera front-end. Generates the sensor XCLK, synchronises the
//             asynchronous href/vsync/pclk/data bus into clk, assembles
//             multi-beat pixels, tracks column/row and emits only pixels that
//             fall inside a latched crop window, each with a linear buffer
//             write address. Grabs one frame per capture request, or runs
//             continuously.
//  Ports    : clk, res          - system clock, synchronous active-high reset
//             capture           - one-cycle request to grab the next frame
//             continuous        - re-arm automatically after each frame
//             cfg_x0/x1/y0/y1   - inclusive crop window (latched on arm)
//             ahref/avsync      - async sensor line valid / frame sync
//             apclk/adata       - async sensor pixel clock / data bus
//             xclk              - sensor master clock (clk / XCLK_DIV)
//             pix_valid         - strobe for an in-window pixel
//             pix_data/addr/x/y - pixel, buffer address and position
//             frame_start/done  - frame boundary pulses
//             busy              - high from arm until frame_done
//             overrun           - sticky, set when the write address wraps
//  Revision : 1.0 - initial release
// ============================================================================
module cam_capture_window #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int XCLK_DIV      = 4,
  parameter int H_W           = 11,
  parameter int V_W           = 10,
  parameter int ADDR_W        = 12
) (
  input  logic                            clk,
  input  logic                            res,
  input  logic                            capture,
  input  logic                            continuous,
  input  logic [H_W-1:0]                  cfg_x0,
  input  logic [H_W-1:0]                  cfg_x1,
  input  logic [V_W-1:0]                  cfg_y0,
  input  logic [V_W-1:0]                  cfg_y1,
  input  logic                            ahref,
  input  logic                            avsync,
  input  logic                            apclk,
  input  logic [DATA_W-1:0]               adata,
  output logic                            xclk,
  output logic                            pix_valid,
  output logic [DATA_W*BYTES_PER_PIX-1:0] pix_data,
  output logic [ADDR_W-1:0]               pix_addr,
  output logic [H_W-1:0]                  pix_x,
  output logic [V_W-1:0]                  pix_y,
  output logic                            frame_start,
  output logic                            frame_done,
  output logic                            busy,
  output logic                            overrun
);

  localparam int c_PIX_W  = DATA_W * BYTES_PER_PIX;
  localparam int c_BC_W   = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam int c_XC_W   = $clog2(XCLK_DIV);
  localparam logic [c_BC_W-1:0] c_LAST_BEAT = c_BC_W'(BYTES_PER_PIX - 1);
  localparam logic [c_BC_W-1:0] c_BEAT_ONE  = c_BC_W'(1);
  localparam logic [c_XC_W-1:0] c_XC_LAST   = c_XC_W'(XCLK_DIV / 2 - 1);
  localparam logic [c_XC_W-1:0] c_XC_ONE    = c_XC_W'(1);
  localparam logic [H_W-1:0]    c_COL_ONE   = H_W'(1);
  localparam logic [V_W-1:0]    c_ROW_ONE   = V_W'(1);
  localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_SYNC   = 3'd2,
    S_ACTIVE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t r_state, w_state_next;

  // --------------------------------------------------------------------------
  // XCLK divider: free-running, unaffected by the capture FSM
  // --------------------------------------------------------------------------
  logic [c_XC_W-1:0] r_xcnt;
  logic              r_xclk;

  always_ff @(posedge clk) begin
    if (res) begin
      r_xcnt <= '0;
      r_xclk <= 1'b0;
    end else if (r_xcnt == c_XC_LAST) begin
      r_xcnt <= '0;
      r_xclk <= ~r_xclk;
    end else begin
      r_xcnt <= r_xcnt + c_XC_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Input synchronisers. Data goes through the same two stages as pclk so
  // r_data_s2 is the byte that was on the bus when the synchronised edge rose.
  // --------------------------------------------------------------------------
  logic              r_href_s1, r_href_s2, r_href_s3;
  logic              r_vs_s1,   r_vs_s2,   r_vs_s3;
  logic              r_pclk_s1, r_pclk_s2, r_pclk_s3;
  logic [DATA_W-1:0] r_data_s1, r_data_s2;

  always_ff @(posedge clk) begin
    if (res) begin
      r_href_s1 <= 1'b0; r_href_s2 <= 1'b0; r_href_s3 <= 1'b0;
      r_vs_s1   <= 1'b0; r_vs_s2   <= 1'b0; r_vs_s3   <= 1'b0;
      r_pclk_s1 <= 1'b0; r_pclk_s2 <= 1'b0; r_pclk_s3 <= 1'b0;
      r_data_s1 <= '0;   r_data_s2 <= '0;
    end else begin
      r_href_s1 <= ahref;  r_href_s2 <= r_href_s1; r_href_s3 <= r_href_s2;
      r_vs_s1   <= avsync; r_vs_s2   <= r_vs_s1;   r_vs_s3   <= r_vs_s2;
      r_pclk_s1 <= apclk;  r_pclk_s2 <= r_pclk_s1; r_pclk_s3 <= r_pclk_s2;
      r_data_s1 <= adata;  r_data_s2 <= r_data_s1;
    end
  end

  logic w_beat, w_href_rise, w_href_fall, w_vs_rise, w_vs_fall;
  assign w_beat      = r_pclk_s2 & ~r_pclk_s3;
  assign w_href_rise = r_href_s2 & ~r_href_s3;
  assign w_href_fall = ~r_href_s2 & r_href_s3;
  assign w_vs_rise   = r_vs_s2 & ~r_vs_s3;
  assign w_vs_fall   = ~r_vs_s2 & r_vs_s3;

  // --------------------------------------------------------------------------
  // Capture FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (res) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    frame_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (capture) w_state_next = S_ARM;
      end
      // Waiting for vsync high skips whatever is left of a frame in progress
      S_ARM:    if (r_vs_s2)   w_state_next = S_SYNC;
      S_SYNC:   if (w_vs_fall) w_state_next = S_ACTIVE;
      S_ACTIVE: if (w_vs_rise) w_state_next = S_DONE;
      S_DONE: begin
        frame_done   = 1'b1;
        w_state_next = continuous ? S_SYNC : S_IDLE;
      end
      default: begin
        busy         = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pixel assembly, position tracking, windowing
  // --------------------------------------------------------------------------
  logic [c_BC_W-1:0]  r_beat;
  logic [H_W-1:0]     r_col;
  logic [V_W-1:0]     r_row;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_line_has_pix;
  logic [H_W-1:0]     r_x0, r_x1;
  logic [V_W-1:0]     r_y0, r_y1;
  logic               r_pix_valid;
  logic [c_PIX_W-1:0] r_pix_data;
  logic [ADDR_W-1:0]  r_pix_addr;
  logic [H_W-1:0]     r_pix_x;
  logic [V_W-1:0]     r_pix_y;
  logic               r_frame_start;
  logic               r_overrun;

  logic [c_PIX_W-1:0] w_pix_next;
  logic [c_BC_W-1:0]  w_beat_cur;
  logic [H_W-1:0]     w_col_cur;
  logic               w_take, w_last, w_in_win;

  // A beat landing on the same cycle as href rising is the first beat of
  // the new line, so the line-start clear is folded in combinationally.
  assign w_beat_cur = w_href_rise ? '0 : r_beat;
  assign w_col_cur  = w_href_rise ? '0 : r_col;
  assign w_take     = (r_state == S_ACTIVE) && w_beat && r_href_s2;
  assign w_last     = (w_beat_cur == c_LAST_BEAT);
  assign w_in_win   = (w_col_cur >= r_x0) && (w_col_cur <= r_x1) &&
                      (r_row >= r_y0) && (r_row <= r_y1);

  generate
    if (BYTES_PER_PIX > 1) begin : g_multi
      localparam int c_SH_W = c_PIX_W - DATA_W;
      logic [c_SH_W-1:0] r_shift;
      // Earlier beats sit above the current one: first beat ends up as MSBs
      assign w_pix_next = {r_shift, r_data_s2};
      always_ff @(posedge clk) begin
        if (res)         r_shift <= '0;
        else if (w_take) r_shift <= w_pix_next[c_SH_W-1:0];
      end
    end else begin : g_single
      assign w_pix_next = r_data_s2;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (res) begin
      r_beat         <= '0;
      r_col          <= '0;
      r_row          <= '0;
      r_addr         <= '0;
      r_line_has_pix <= 1'b0;
      r_x0           <= '0;
      r_x1           <= '0;
      r_y0           <= '0;
      r_y1           <= '0;
      r_pix_valid    <= 1'b0;
      r_pix_data     <= '0;
      r_pix_addr     <= '0;
      r_pix_x        <= '0;
      r_pix_y        <= '0;
      r_frame_start  <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_pix_valid   <= 1'b0;
      r_frame_start <= 1'b0;

      if ((r_state == S_ARM) || ((r_state == S_DONE) && continuous)) begin
        r_x0 <= cfg_x0;
        r_x1 <= cfg_x1;
        r_y0 <= cfg_y0;
        r_y1 <= cfg_y1;
      end
      if (r_state == S_ARM) r_overrun <= 1'b0;

      if ((r_state == S_SYNC) && w_vs_fall) begin
        r_frame_start  <= 1'b1;
        r_row          <= '0;
        r_col          <= '0;
        r_addr         <= '0;
        r_beat         <= '0;
        r_line_has_pix <= 1'b0;
      end else if (r_state == S_ACTIVE) begin
        if (w_href_rise) begin
          r_beat         <= '0;
          r_col          <= '0;
          r_line_has_pix <= 1'b0;
        end
        // Falling href drops any partial pixel; empty lines don't count
        if (w_href_fall) begin
          r_beat <= '0;
          if (r_line_has_pix && (r_row != {V_W{1'b1}})) r_row <= r_row + c_ROW_ONE;
        end
        if (w_take) begin
          if (w_last) begin
            r_beat         <= '0;
            r_line_has_pix <= 1'b1;
            if (w_col_cur != {H_W{1'b1}}) r_col <= w_col_cur + c_COL_ONE;
            else                          r_col <= w_col_cur;
            if (w_in_win) begin
              r_pix_valid <= 1'b1;
              r_pix_data  <= w_pix_next;
              r_pix_x     <= w_col_cur;
              r_pix_y     <= r_row;
              r_pix_addr  <= r_addr;
              r_addr      <= r_addr + c_ADDR_ONE;
              if (r_addr == {ADDR_W{1'b1}}) r_overrun <= 1'b1;
            end
          end else begin
            r_beat <= w_beat_cur + c_BEAT_ONE;
          end
        end
      end
    end
  end

  assign xclk        = r_xclk;
  assign pix_valid   = r_pix_valid;
  assign pix_data    = r_pix_data;
  assign pix_addr    = r_pix_addr;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign frame_start = r_frame_start;
  assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_cam_capture_window.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cam_capture_window
//  Purpose  : Self-checking bench for cam_capture_window. A vector table of
//             crop-window frames is replayed and every emitted pixel is
//             compared with a small frame model; hand-written sequences cover
//             reset/xclk, address wrap, arm timing, continuous mode and reset
//             in mid-line. A second instance with a 3-bit address is used
//             for the wrap/overrun case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cam_capture_window;

  logic        clk = 1'b0;
  logic        res, capture, continuous;
  logic [10:0] cfg_x0, cfg_x1;
  logic [9:0]  cfg_y0, cfg_y1;
  logic        ahref, avsync, apclk;
  logic [7:0]  adata;

  logic        xclk, pix_valid, frame_start, frame_done, busy, overrun;
  logic [15:0] pix_data;
  logic [11:0] pix_addr;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;

  logic        xclk_w, pix_valid_w, frame_start_w, frame_done_w, busy_w, overrun_w;
  logic [15:0] pix_data_w;
  logic [2:0]  pix_addr_w;
  logic [10:0] pix_x_w;
  logic [9:0]  pix_y_w;

  always #5 clk = ~clk;

  cam_capture_window #(.DATA_W(8), .BYTES_PER_PIX(2), .XCLK_DIV(4), .H_W(11), .V_W(10), .ADDR_W(12)) u_dut (
    .clk(clk), .res(res), .capture(capture), .continuous(continuous),
    .cfg_x0(cfg_x0), .cfg_x1(cfg_x1), .cfg_y0(cfg_y0), .cfg_y1(cfg_y1),
    .ahref(ahref), .avsync(avsync), .apclk(apclk), .adata(adata),
    .xclk(xclk), .pix_valid(pix_valid), .pix_data(pix_data), .pix_addr(pix_addr),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .frame_done(frame_done),
    .busy(busy), .overrun(overrun)
  );

  cam_capture_window #(.DATA_W(8), .BYTES_PER_PIX(2), .XCLK_DIV(4), .H_W(11), .V_W(10), .ADDR_W(3)) u_dut_w (
    .clk(clk), .res(res), .capture(capture), .continuous(continuous),
    .cfg_x0(cfg_x0), .cfg_x1(cfg_x1), .cfg_y0(cfg_y0), .cfg_y1(cfg_y1),
    .ahref(ahref), .avsync(avsync), .apclk(apclk), .adata(adata),
    .xclk(xclk_w), .pix_valid(pix_valid_w), .pix_data(pix_data_w), .pix_addr(pix_addr_w),
    .pix_x(pix_x_w), .pix_y(pix_y_w), .frame_start(frame_start_w), .frame_done(frame_done_w),
    .busy(busy_w), .overrun(overrun_w)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [10:0] x;
    logic [9:0]  y;
    logic [11:0] addr;
  } pix_t;

  typedef struct {
    int x0, x1, y0, y1;
    int nl, np;
    bit vary, odd;
    int exp_cnt;
    int fx, fy, lx, ly;
  } vec_t;

  pix_t       q[$];
  logic [2:0] qw[$];
  int         fs_cnt = 0;
  int         fd_cnt = 0;
  bit         watch_busy = 1'b0;
  bit         busy_low_seen = 1'b0;
  int         n_checks = 0;
  int         n_err = 0;

  // Output monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (pix_valid)   q.push_back('{pix_data, pix_x, pix_y, pix_addr});
    if (pix_valid_w) qw.push_back(pix_addr_w);
    if (frame_start) fs_cnt++;
    if (frame_done)  fd_cnt++;
    if (watch_busy && !busy) busy_low_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [7:0] b);
    adata = b;
    repeat (2) @(negedge clk);
    apclk = 1'b1;
    repeat (2) @(negedge clk);
    apclk = 1'b0;
  endtask

  task automatic send_line(input int row, input int np, input bit vary, input bit odd);
    ahref = 1'b1;
    repeat (4) @(negedge clk);
    for (int c = 0; c < np; c++) begin
      beat(vary ? 8'(8'h10 + c) : 8'hA5);
      beat(vary ? 8'(8'h40 + row) : 8'h3C);
    end
    if (odd) beat(8'hEE);
    repeat (2) @(negedge clk);
    ahref = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic vs_fall();
    avsync = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic vs_rise();
    avsync = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic run_frame(input int nl, input int np, input bit vary, input bit odd);
    vs_fall();
    for (int r = 0; r < nl; r++) send_line(r, np, vary, odd);
    vs_rise();
  endtask

  task automatic pulse_capture();
    capture = 1'b1;
    @(negedge clk);
    capture = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic set_win(input int x0, input int x1, input int y0, input int y1);
    cfg_x0 = 11'(x0); cfg_x1 = 11'(x1);
    cfg_y0 = 10'(y0); cfg_y1 = 10'(y1);
  endtask

  vec_t vecs[6];
  int   qb, qb2, qwb, fsb, fdb, k;
  logic [7:0] hi, lo;

  initial begin
    //              x0 x1 y0 y1 nl np vary  odd  cnt fx fy lx ly
    vecs[0] = '{0, 3, 0, 1, 2, 4, 1'b0, 1'b0, 8, 0, 0, 3, 1};  // full frame
    vecs[1] = '{2, 5, 1, 2, 4, 8, 1'b1, 1'b0, 8, 2, 1, 5, 2};  // crop
    vecs[2] = '{5, 2, 0, 3, 4, 8, 1'b1, 1'b0, 0, 0, 0, 0, 0};  // empty x
    vecs[3] = '{7, 7, 3, 3, 4, 8, 1'b1, 1'b0, 1, 7, 3, 7, 3};  // single pixel
    vecs[4] = '{0, 7, 0, 3, 2, 3, 1'b1, 1'b1, 6, 0, 0, 2, 1};  // odd byte per line
    vecs[5] = '{0, 7, 3, 2, 2, 4, 1'b1, 1'b0, 0, 0, 0, 0, 0};  // empty y

    res = 1'b1; capture = 1'b0; continuous = 1'b0;
    ahref = 1'b0; avsync = 1'b1; apclk = 1'b0; adata = 8'h00;
    set_win(0, 0, 0, 0);

    // ---------------- reset state and xclk ----------------
    repeat (3) @(negedge clk);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_pix_bus", {pix_data, pix_addr, pix_x, pix_y}, 0);
    check("rst_xclk", xclk, 0);
    res = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("xclk_cyc%0d", i), xclk, (i / 2) % 2);
    end
    repeat (4) @(negedge clk);

    // ---------------- table-driven frames ----------------
    for (int v = 0; v < 6; v++) begin
      set_win(vecs[v].x0, vecs[v].x1, vecs[v].y0, vecs[v].y1);
      qb = q.size(); fsb = fs_cnt; fdb = fd_cnt;
      pulse_capture();
      check($sformatf("v%0d_busy_armed", v), busy, 1);
      run_frame(vecs[v].nl, vecs[v].np, vecs[v].vary, vecs[v].odd);
      check($sformatf("v%0d_count", v), q.size() - qb, vecs[v].exp_cnt);
      k = 0;
      for (int r = 0; r < vecs[v].nl; r++) begin
        for (int c = 0; c < vecs[v].np; c++) begin
          if (c >= vecs[v].x0 && c <= vecs[v].x1 && r >= vecs[v].y0 && r <= vecs[v].y1) begin
            hi = vecs[v].vary ? 8'(8'h10 + c) : 8'hA5;
            lo = vecs[v].vary ? 8'(8'h40 + r) : 8'h3C;
            if (qb + k < q.size()) begin
              check($sformatf("v%0d_pix%0d_data", v, k), q[qb + k].data, {hi, lo});
              check($sformatf("v%0d_pix%0d_xya", v, k),
                    {q[qb + k].x, q[qb + k].y, q[qb + k].addr},
                    {11'(c), 10'(r), 12'(k)});
            end
            k++;
          end
        end
      end
      if (vecs[v].exp_cnt > 0 && q.size() - qb == vecs[v].exp_cnt) begin
        check($sformatf("v%0d_first_xy", v), {q[qb].x, q[qb].y}, {11'(vecs[v].fx), 10'(vecs[v].fy)});
        check($sformatf("v%0d_last_xya", v), {q[q.size() - 1].x, q[q.size() - 1].y, q[q.size() - 1].addr},
              {11'(vecs[v].lx), 10'(vecs[v].ly), 12'(vecs[v].exp_cnt - 1)});
      end
      check($sformatf("v%0d_frame_start", v), fs_cnt - fsb, 1);
      check($sformatf("v%0d_frame_done", v), fd_cnt - fdb, 1);
      check($sformatf("v%0d_busy_end", v), busy, 0);
    end

    // ---------------- address wrap / overrun (3-bit address instance) -------
    set_win(0, 4, 0, 1);
    qb = q.size(); qwb = qw.size();
    pulse_capture();
    check("ovr_cleared_on_arm", overrun_w, 0);
    run_frame(2, 5, 1'b1, 1'b0);
    check("ovr_count_w", qw.size() - qwb, 10);
    for (int i = 0; i < 10; i++)
      if (qwb + i < qw.size()) check($sformatf("ovr_addr_w%0d", i), qw[qwb + i], i % 8);
    check("ovr_flag_w", overrun_w, 1);
    check("ovr_count_main", q.size() - qb, 10);
    if (q.size() - qb == 10) check("ovr_last_addr_main", q[q.size() - 1].addr, 9);
    check("ovr_flag_main", overrun, 0);

    // ---------------- arm timing: capture mid-frame --------------------------
    set_win(0, 3, 0, 1);
    qb = q.size(); fsb = fs_cnt; fdb = fd_cnt;
    vs_fall();
    send_line(0, 4, 1'b0, 1'b0);
    pulse_capture();
    check("arm_busy", busy, 1);
    check("arm_ovr_clear_w", overrun_w, 0);
    send_line(1, 4, 1'b0, 1'b0);
    vs_rise();
    check("arm_no_pix_partial_frame", q.size() - qb, 0);
    check("arm_no_done_partial_frame", fd_cnt - fdb, 0);
    vs_fall();
    pulse_capture();                       // ignored: already busy
    send_line(0, 4, 1'b0, 1'b0);
    send_line(1, 4, 1'b0, 1'b0);
    vs_rise();
    check("arm_count", q.size() - qb, 8);
    if (q.size() - qb == 8) begin
      check("arm_first_addr", q[qb].addr, 0);
      check("arm_last_xya", {q[qb + 7].x, q[qb + 7].y, q[qb + 7].addr}, {11'd3, 10'd1, 12'd7});
    end
    check("arm_frame_start", fs_cnt - fsb, 1);
    check("arm_frame_done", fd_cnt - fdb, 1);
    check("arm_busy_end", busy, 0);

    // ---------------- continuous mode, cfg re-latch between frames ----------
    set_win(0, 3, 0, 1);
    continuous = 1'b1;
    qb = q.size(); fsb = fs_cnt; fdb = fd_cnt;
    pulse_capture();
    watch_busy = 1'b1;
    vs_fall();
    send_line(0, 4, 1'b0, 1'b0);
    send_line(1, 4, 1'b0, 1'b0);
    cfg_x1 = 11'd1;                        // takes effect only for frame 2
    vs_rise();
    check("cont_f1_count", q.size() - qb, 8);
    if (q.size() - qb == 8) check("cont_f1_last_addr", q[qb + 7].addr, 7);
    check("cont_f1_done", fd_cnt - fdb, 1);
    check("cont_busy_between", busy, 1);
    qb2 = q.size();
    vs_fall();
    send_line(0, 4, 1'b0, 1'b0);
    continuous = 1'b0;                     // stop after this frame
    send_line(1, 4, 1'b0, 1'b0);
    avsync = 1'b1;
    watch_busy = 1'b0;
    repeat (10) @(negedge clk);
    check("cont_f2_count", q.size() - qb2, 4);
    if (q.size() - qb2 == 4) begin
      check("cont_f2_first_xya", {q[qb2].x, q[qb2].y, q[qb2].addr}, {11'd0, 10'd0, 12'd0});
      check("cont_f2_last_xya", {q[qb2 + 3].x, q[qb2 + 3].y, q[qb2 + 3].addr}, {11'd1, 10'd1, 12'd3});
    end
    check("cont_frame_start", fs_cnt - fsb, 2);
    check("cont_frame_done", fd_cnt - fdb, 2);
    check("cont_busy_held", busy_low_seen, 0);
    check("cont_busy_end", busy, 0);

    // ---------------- reset in mid-line, then a normal capture --------------
    set_win(0, 3, 0, 1);
    pulse_capture();
    vs_fall();
    ahref = 1'b1;
    repeat (4) @(negedge clk);
    beat(8'hA5); beat(8'h3C); beat(8'hA5);
    fdb = fd_cnt;
    res = 1'b1;
    repeat (2) @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    check("mres_pix_valid", pix_valid, 0);
    check("mres_busy", busy, 0);
    repeat (4) @(negedge clk);
    ahref = 1'b0;
    repeat (4) @(negedge clk);
    vs_rise();
    check("mres_no_done", fd_cnt - fdb, 0);
    qb = q.size(); fdb = fd_cnt;
    pulse_capture();
    run_frame(2, 4, 1'b0, 1'b0);
    check("mres_recap_count", q.size() - qb, 8);
    if (q.size() - qb == 8) begin
      check("mres_recap_first", {q[qb].data, q[qb].addr}, {16'hA53C, 12'd0});
      check("mres_recap_last_addr", q[qb + 7].addr, 7);
    end
    check("mres_recap_done", fd_cnt - fdb, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
